reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
Parametrised multi-port general-purpose register file. It is the successor to the single-write, dual-read 32x32 file. It adds configurable width, depth and read-port count, a second write port, optional write-to-read bypass, and a hardware scrub sequencer that zeroes every entry after reset or on request. It sits in the decode stage and feeds the operand muxes.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of asynchronous read ports (1..4)
ZERO_REG, 1, when 1, entry 0 reads as 0 and writes to entry 0 are discarded
BYPASS, 1, when 1, a read of an address written this cycle returns the incoming write data

Ports:
CLK  in  1  clock; all state updates on its rising edge
RST  in  1  asynchronous, active-high reset
RADDR  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
RDATA  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
W0_EN  in  1  write port 0 enable
W0_ADDR  in  ADDR_W  write port 0 address
W0_DATA  in  DATA_W  write port 0 data
W1_EN  in  1  write port 1 enable; takes priority over port 0
W1_ADDR  in  ADDR_W  write port 1 address
W1_DATA  in  DATA_W  write port 1 data
CLR_REQ  in  1  single-cycle request to scrub all entries to 0
BUSY  out  1  high while the scrub is in progress; the file is unavailable
WR_DROP  out  1  registered one-cycle pulse: a write was discarded because BUSY was high

Behaviour:
- FSM has two states, IDLE and SCRUB. Scrub pointer SPTR is ADDR_W bits wide.
- Reset (asynchronous): state=SCRUB, SPTR=0, WR_DROP=0. BUSY=1 while RST is high and afterwards until the scrub completes. Array contents are not reset asynchronously.
- SCRUB: on each edge, entry[SPTR] <= 0 and SPTR <= SPTR+1.
  - At the edge where SPTR==DEPTH-1, the last entry is written, state goes to IDLE and SPTR wraps to 0.
  - The scrub therefore lasts exactly DEPTH cycles.
- IDLE, with CLR_REQ=1: state goes to SCRUB and SPTR=0 at the next edge. BUSY rises on the following cycle. Writes on the request cycle are still performed.
- CLR_REQ while in SCRUB is ignored. The scrub is not restarted or extended.
- RST asserted mid-scrub restarts the scrub from SPTR=0.
- BUSY = (state==SCRUB). It is combinational from the state register, so it is glitch-free.
- Writes (IDLE only): on the rising edge, W0 then W1 are applied.
  - If both are enabled to the same address, W1_DATA wins.
  - If ZERO_REG=1, writes to address 0 are discarded silently; WR_DROP does not pulse.
- Writes during SCRUB are discarded. WR_DROP=1 on the next cycle if W0_EN or W1_EN was high; otherwise WR_DROP=0.
- Reads are asynchronous (combinational), one per port, with this priority:
  1. BUSY=1 -> 0
  2. ZERO_REG=1 and addr==0 -> 0
  3. BYPASS=1 and W1_EN and W1_ADDR==addr -> W1_DATA
  4. BYPASS=1 and W0_EN and W0_ADDR==addr -> W0_DATA
  5. otherwise entry[addr]
- With BYPASS=0, read data is pre-write (old) data during the write cycle.
- Reset value of RDATA is 0 on all ports, because BUSY=1.
- No arithmetic beyond the SPTR increment. SPTR wraps modulo DEPTH.
- All read ports are independent; any number may address the same entry.

Test Plan:
- Reset then idle, with DATA_W=32, ADDR_W=5 -> BUSY high for exactly 32 cycles after RST falls; all RDATA=0; afterwards every entry reads 0x00000000.
- IDLE: W0 writes addr 3 = 0xDEADBEEF; next cycle RADDR[0]=3 -> RDATA[0]=0xDEADBEEF. With BYPASS=1, same-cycle read of addr 3 -> 0xDEADBEEF; with BYPASS=0 -> old value 0.
- Write to addr 0 = 0x12345678 with ZERO_REG=1 -> addr 0 reads 0; WR_DROP stays 0. With ZERO_REG=0 -> addr 0 reads 0x12345678.
- W0 (addr 7 = 0x11111111) and W1 (addr 7 = 0x22222222) in the same cycle -> addr 7 reads 0x22222222; same-cycle bypass returns 0x22222222.
- Fill addr 5 = 0xA5A5A5A5, pulse CLR_REQ, write addr 9 = 1 on cycle 4 of the scrub -> BUSY for 32 cycles; WR_DROP pulses once; addr 5 and addr 9 read 0 afterwards.
- Pulse CLR_REQ again at scrub cycle 10, then assert RST at scrub cycle 20 -> the second CLR_REQ is ignored; after RST falls, BUSY lasts a full 32 cycles from SPTR=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port general-purpose register file with dual write ports,
// optional write-to-read bypass and a post-reset / on-request scrub sequencer.
module reg_file_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NUM_RD*ADDR_W-1:0]   RADDR,
   output logic [NUM_RD*DATA_W-1:0]   RDATA,
   input  logic                       W0_EN,
   input  logic [ADDR_W-1:0]          W0_ADDR,
   input  logic [DATA_W-1:0]          W0_DATA,
   input  logic                       W1_EN,
   input  logic [ADDR_W-1:0]          W1_ADDR,
   input  logic [DATA_W-1:0]          W1_DATA,
   input  logic                       CLR_REQ,
   output logic                       BUSY,
   output logic                       WR_DROP
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [0:0] {StIdle, StScrub} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] sptr_q;
   logic              wr_drop_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic w0_ok;
   logic w1_ok;

   // Entry 0 is hardwired to zero when ZERO_REG is set, so its writes are dropped silently.
   assign w0_ok = W0_EN && !(ZERO_REG && (W0_ADDR == '0));
   assign w1_ok = W1_EN && !(ZERO_REG && (W1_ADDR == '0));

   assign BUSY    = (state_q == StScrub);
   assign WR_DROP = wr_drop_q;

   // Scrub sequencer: walks SPTR across every entry, then returns to idle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StScrub;
         sptr_q    <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               wr_drop_q <= 1'b0;
               if (CLR_REQ) begin
                  state_q <= StScrub;
                  sptr_q  <= '0;
               end
            end
            StScrub: begin
               // Writes arriving while busy are discarded and flagged one cycle later.
               wr_drop_q <= W0_EN | W1_EN;
               sptr_q    <= sptr_q + ADDR_W'(1);
               if (sptr_q == '1) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q   <= StIdle;
               wr_drop_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage array: scrub zeroes one entry per cycle, otherwise W0 then W1 (W1 wins).
   always_ff @(posedge CLK) begin
      if (BUSY) begin
         mem_q[sptr_q] <= '0;
      end else begin
         if (w0_ok) begin
            mem_q[W0_ADDR] <= W0_DATA;
         end
         if (w1_ok) begin
            mem_q[W1_ADDR] <= W1_DATA;
         end
      end
   end

   // Asynchronous read ports; later assignments carry higher priority.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      RDATA = '0;
      ra    = '0;
      rd    = '0;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         ra = RADDR[i*ADDR_W +: ADDR_W];
         rd = mem_q[ra];
         if (BYPASS && W0_EN && (W0_ADDR == ra)) begin
            rd = W0_DATA;
         end
         if (BYPASS && W1_EN && (W1_ADDR == ra)) begin
            rd = W1_DATA;
         end
         if (ZERO_REG && (ra == '0)) begin
            rd = '0;
         end
         if (BUSY) begin
            rd = '0;
         end
         RDATA[i*DATA_W +: DATA_W] = rd;
      end
   end

endmodule
